// File: rtl/keypad_scan_pkg.sv
// Shared types, key codes and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } kp_state_e;

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_CLR   = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  // (row,col) -> logical key code, row-major keypad layout:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D   with * = E and # = F
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest-numbered active-low row: {found, index}.
  function automatic logic [2:0] first_low_row(input logic [3:0] row);
    logic [2:0] res;
    if (!row[0]) begin
      res = 3'b100;
    end else if (!row[1]) begin
      res = 3'b101;
    end else if (!row[2]) begin
      res = 3'b110;
    end else if (!row[3]) begin
      res = 3'b111;
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  // Three BCD digits to binary (max 999 fits in 10 bits).
  function automatic logic [9:0] bcd3_to_bin(input logic [3:0] d2, input logic [3:0] d1,
                                              input logic [3:0] d0);
    logic [9:0] v;
    v = ({6'd0, d2} * 10'd100) + ({6'd0, d1} * 10'd10) + {6'd0, d0};
    return v;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// CPU-facing memoryio bus of the keypad scanner.
interface keypad_scan_if;
  logic        key_cs;
  logic        key_read;
  logic [15:0] key_rdata;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_pressed;

  modport master (
    output key_cs, key_read,
    input  key_rdata, key_valid, key_code, key_pressed
  );

  modport slave (
    input  key_cs, key_read,
    output key_rdata, key_valid, key_code, key_pressed
  );
endinterface

// File: rtl/keypad_scan_tick.sv
// Scan-rate divider: one-cycle tick every SCAN_DIV clock cycles.
module keypad_tick
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic scan_clk,
  input  logic scan_rst,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Wrap the counter and flag the wrap cycle.
  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Divider registers.
  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and a 3-digit decimal entry buffer.
// Rows are synchronised through two flops; SCAN_DIV must leave at least three
// cycles between ticks so a new column drive is visible at the next sample.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 4
) (
  input  logic          scan_clk,
  input  logic          scan_rst,
  input  logic [3:0]    key_row,
  output logic [3:0]    key_col,
  keypad_scan_if.slave  bus
);

  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);

  logic            tick_s;
  logic [3:0]      row_meta_q, row_meta_d, row_sync_q, row_sync_d;
  kp_state_e       state_q, state_d;
  logic [1:0]      col_idx_q, col_idx_d, row_idx_q, row_idx_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [3:0]      key_col_q, key_col_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_pressed_q, key_pressed_d;
  logic            key_valid_q, key_valid_d;
  logic [2:0][3:0] digits_q, digits_d;
  logic [1:0]      count_q, count_d;
  logic [9:0]      value_q, value_d;
  logic            accept_s, any_low_s, read_s;
  logic [2:0]      low_s;
  logic [3:0]      accept_code_s;

  keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .scan_clk (scan_clk),
    .scan_rst (scan_rst),
    .tick     (tick_s)
  );

  // Two-flop synchroniser for the asynchronous row lines.
  always_comb begin
    row_meta_d = key_row;
    row_sync_d = row_meta_q;
  end

  // Scan FSM: next state, column pointer, debounce count and key acceptance.
  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    row_idx_d     = row_idx_q;
    deb_cnt_d     = deb_cnt_q;
    accept_s      = 1'b0;
    any_low_s     = (row_sync_q != 4'hF);
    low_s         = first_low_row(row_sync_q);
    accept_code_s = key_map(row_idx_q, col_idx_q);
    if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (any_low_s) begin
            state_d   = ST_SCAN;
            col_idx_d = 2'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (low_s[2]) begin
            state_d   = ST_DEBOUNCE;
            row_idx_d = low_s[1:0];
            deb_cnt_d = '0;
          end else if (col_idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (low_s[2] && (low_s[1:0] == row_idx_q)) begin
            if (deb_cnt_q == DEB_LAST) begin
              state_d  = ST_HELD;
              accept_s = 1'b1;
            end else begin
              deb_cnt_d = deb_cnt_q + DW'(1);
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!any_low_s) begin
            state_d   = ST_RELEASE;
            deb_cnt_d = '0;
          end else begin
            state_d = ST_HELD;
          end
        end
        ST_RELEASE: begin
          if (any_low_s) begin
            state_d = ST_HELD;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d = ST_IDLE;
          end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    case (state_d)
      ST_IDLE: key_col_d = 4'b0000;
      default: key_col_d = ~(4'b0001 << col_idx_d);
    endcase
  end

  // Entry buffer, key event outputs and the CPU valid flag.
  always_comb begin
    read_s        = bus.key_cs && bus.key_read;
    key_code_d    = key_code_q;
    key_pressed_d = 1'b0;
    digits_d      = digits_q;
    count_d       = count_q;
    value_d       = bcd3_to_bin(digits_q[2], digits_q[1], digits_q[0]);
    if (accept_s) begin
      key_code_d    = accept_code_s;
      key_pressed_d = 1'b1;
      if (accept_code_s <= 4'd9) begin
        if (count_q != 2'd3) begin
          digits_d = {digits_q[1], digits_q[0], accept_code_s};
          count_d  = count_q + 2'd1;
        end else begin
          count_d = count_q;
        end
      end else begin
        case (accept_code_s)
          KEY_BKSP: begin
            if (count_q != 2'd0) begin
              digits_d = {4'd0, digits_q[2], digits_q[1]};
              count_d  = count_q - 2'd1;
            end else begin
              count_d = count_q;
            end
          end
          KEY_CLR: begin
            digits_d = '0;
            count_d  = 2'd0;
          end
          default: count_d = count_q;
        endcase
      end
    end else begin
      key_code_d = key_code_q;
    end
    // A fresh enter outranks a concurrent read-acknowledge.
    if (accept_s && (accept_code_s == KEY_ENTER)) begin
      key_valid_d = 1'b1;
    end else if (read_s && key_valid_q) begin
      key_valid_d = 1'b0;
    end else begin
      key_valid_d = key_valid_q;
    end
  end

  // Scan FSM state register and column drive.
  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      state_q   <= ST_IDLE;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      deb_cnt_q <= '0;
      key_col_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      deb_cnt_q <= deb_cnt_d;
      key_col_q <= key_col_d;
    end
  end

  // Synchroniser, entry buffer and output registers.
  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      row_meta_q    <= 4'hF;
      row_sync_q    <= 4'hF;
      key_code_q    <= 4'h0;
      key_pressed_q <= 1'b0;
      key_valid_q   <= 1'b0;
      digits_q      <= '0;
      count_q       <= 2'd0;
      value_q       <= 10'd0;
    end else begin
      row_meta_q    <= row_meta_d;
      row_sync_q    <= row_sync_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      key_valid_q   <= key_valid_d;
      digits_q      <= digits_d;
      count_q       <= count_d;
      value_q       <= value_d;
    end
  end

  assign key_col         = key_col_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_pressed = key_pressed_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_rdata   = read_s ? {6'd0, value_q} : 16'd0;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomised and directed bench for keypad_scan against a queue-based entry model.
module tb_keypad_scan;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_TICKS = 2;

  logic       scan_clk = 1'b0;
  logic       scan_rst;
  logic [3:0] key_row;
  logic [3:0] key_col;

  keypad_scan_if bus ();

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)) dut (
    .scan_clk (scan_clk),
    .scan_rst (scan_rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .bus      (bus)
  );

  always #5 scan_clk = ~scan_clk;

  // Keypad matrix: the pressed key pulls its row low while its column is driven low.
  logic press_on;
  int   pr, pc;
  always_comb begin
    key_row = 4'hF;
    if (press_on && (key_col[pc] == 1'b0)) begin
      key_row[pr] = 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  // Count every cycle that key_pressed is high.
  always @(negedge scan_clk) begin
    if (bus.key_pressed === 1'b1) pulse_cnt++;
  end

  // Reference model: layout table, entered-digit queue, valid flag.
  int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int m_digits[$];
  int m_valid   = 0;
  int m_code    = 0;
  int m_presses = 0;

  function automatic int model_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  task automatic model_key(input int code);
    m_presses++;
    m_code = code;
    if (code <= 9) begin
      if (m_digits.size() < 3) m_digits.push_back(code);
    end else if (code == 10) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (code == 11) begin
      m_digits.delete();
    end else if (code == 15) begin
      m_valid = 1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * SCAN_DIV) @(negedge scan_clk);
  endtask

  task automatic locate(input int code);
    for (int i = 0; i < 16; i++) begin
      if (layout[i] == code) begin
        pr = i / 4;
        pc = i % 4;
      end
    end
  endtask

  task automatic press_code(input int code, input int hold, input int gap);
    locate(code);
    press_on = 1'b1;
    wait_ticks(hold);
    press_on = 1'b0;
    wait_ticks(gap);
    model_key(code);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "/code"}, 32'(bus.key_code), 32'(m_code));
    check_eq({tag, "/pulses"}, 32'(pulse_cnt), 32'(m_presses));
    check_eq({tag, "/valid"}, 32'(bus.key_valid), 32'(m_valid));
  endtask

  task automatic read_value(input string tag);
    bus.key_cs   = 1'b1;
    bus.key_read = 1'b1;
    #1;
    check_eq({tag, "/rdata"}, 32'(bus.key_rdata), 32'(model_value()));
    @(negedge scan_clk);
    bus.key_cs   = 1'b0;
    bus.key_read = 1'b0;
    m_valid      = 0;
    check_eq({tag, "/valid_after_read"}, 32'(bus.key_valid), 32'(m_valid));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int found;
    int guard;
    scan_rst     = 1'b1;
    press_on     = 1'b0;
    pr           = 0;
    pc           = 0;
    bus.key_cs   = 1'b0;
    bus.key_read = 1'b0;
    repeat (3) @(negedge scan_clk);

    // Reset state
    check_eq("rst/col", 32'(key_col), 32'h0);
    check_eq("rst/code", 32'(bus.key_code), 32'h0);
    check_eq("rst/pressed", 32'(bus.key_pressed), 32'h0);
    check_eq("rst/valid", 32'(bus.key_valid), 32'h0);
    bus.key_cs = 1'b1; bus.key_read = 1'b1; #1;
    check_eq("rst/rdata", 32'(bus.key_rdata), 32'h0);
    bus.key_cs = 1'b0; bus.key_read = 1'b0;
    @(negedge scan_clk);
    scan_rst = 1'b0;
    wait_ticks(2);

    // Single key 5 held for 10 ticks
    press_code(5, 10, 8);
    check_status("key5");
    read_value("key5");

    // 1,2,3,4,# -> 123 with the fourth digit dropped
    press_code(11, 10, 8);
    press_code(1, 10, 8);
    press_code(2, 10, 8);
    press_code(3, 10, 8);
    press_code(4, 10, 8);
    press_code(15, 10, 8);
    check_status("enter123");
    check_eq("enter123/valid_set", 32'(bus.key_valid), 32'h1);
    read_value("enter123");

    // Short bounce on key 1: no acceptance, scanner back to idle
    pr = 0; pc = 0;
    press_on = 1'b1;
    wait_ticks(2);
    press_on = 1'b0;
    wait_ticks(10);
    check_eq("bounce/pulses", 32'(pulse_cnt), 32'(m_presses));
    check_eq("bounce/idle_col", 32'(key_col), 32'h0);

    // 4,7,A,9 -> 49, then B -> 0 and count cleared
    press_code(11, 10, 8);
    press_code(4, 10, 8);
    press_code(7, 10, 8);
    press_code(10, 10, 8);
    press_code(9, 10, 8);
    check_status("bksp49");
    read_value("bksp49");
    press_code(11, 10, 8);
    read_value("clear");
    press_code(8, 10, 8);
    press_code(6, 10, 8);
    press_code(2, 10, 8);
    check_status("after_clear");
    read_value("after_clear");

    // Enter coincident with a CPU read keeps valid set
    press_code(15, 10, 8);
    check_eq("enter_rd/pre_valid", 32'(bus.key_valid), 32'h1);
    locate(15);
    press_on = 1'b1;
    found = 0;
    guard = 0;
    while (!found && guard < 40 * SCAN_DIV) begin
      @(negedge scan_clk);
      guard++;
      if (dut.accept_s === 1'b1) found = 1;
    end
    check_eq("enter_rd/accept_seen", 32'(found), 32'h1);
    if (found == 1) begin
      bus.key_cs = 1'b1; bus.key_read = 1'b1;
      @(negedge scan_clk);
      bus.key_cs = 1'b0; bus.key_read = 1'b0;
      check_eq("enter_rd/pressed", 32'(bus.key_pressed), 32'h1);
      check_eq("enter_rd/valid", 32'(bus.key_valid), 32'h1);
    end
    wait_ticks(4);
    press_on = 1'b0;
    wait_ticks(8);
    model_key(15);
    check_status("enter_rd");

    // Randomised key sequence
    for (int n = 0; n < 24; n++) begin
      int code;
      code = layout[$urandom_range(0, 15)];
      press_code(code, $urandom_range(9, 13), $urandom_range(8, 11));
      check_status($sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) read_value($sformatf("rnd%0d", n));
    end

    // Reset while a key is held
    press_code(11, 10, 8);
    press_code(7, 10, 8);
    locate(5);
    press_on = 1'b1;
    wait_ticks(9);
    model_key(5);
    check_eq("held/pulses", 32'(pulse_cnt), 32'(m_presses));
    scan_rst = 1'b1;
    #1;
    check_eq("rst_held/col", 32'(key_col), 32'h0);
    check_eq("rst_held/code", 32'(bus.key_code), 32'h0);
    check_eq("rst_held/pressed", 32'(bus.key_pressed), 32'h0);
    check_eq("rst_held/valid", 32'(bus.key_valid), 32'h0);
    bus.key_cs = 1'b1; bus.key_read = 1'b1; #1;
    check_eq("rst_held/rdata", 32'(bus.key_rdata), 32'h0);
    bus.key_cs = 1'b0; bus.key_read = 1'b0;
    press_on = 1'b0;
    repeat (4) @(negedge scan_clk);
    scan_rst = 1'b0;
    m_digits.delete();
    m_valid = 0;
    m_code  = 0;
    wait_ticks(10);
    check_status("post_rst");
    read_value("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
